mem_bus_responder: RTL and testbench



---
 rtl/mem_bus_responder_pkg.sv | 25 ++
 rtl/mem_wait_counter.sv | 37 +++
 rtl/mem_bus_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_bus_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_responder_pkg
// Types and constants shared by the SysBus memory responder and its
// wait-state counter.
//   BUS_W        : SysBus width (multiplexed address/data)
//   WAIT_W       : width of the read wait-state counter
//   resp_state_t : responder transaction state
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mem_bus_responder_pkg;

   localparam int unsigned BUS_W  = 16;
   localparam int unsigned WAIT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HELD,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_DRIVE,
      S_WR_COMMIT,
      S_WR_HOLD
   } resp_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Loadable down-counter used to insert read wait states. Stops at zero.
//   Clock     in  system clock
//   nReset    in  asynchronous active-low reset (count cleared)
//   i_Load    in  load i_LoadVal (has priority over i_Dec)
//   i_LoadVal in  value to load
//   i_Dec     in  decrement by one when non-zero
//   o_Zero    out count is zero
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_wait_counter
   import mem_bus_responder_pkg::*;
(
   input  logic              Clock,
   input  logic              nReset,
   input  logic              i_Load,
   input  logic [WAIT_W-1:0] i_LoadVal,
   input  logic              i_Dec,
   output logic              o_Zero
);

   logic [WAIT_W-1:0] r_Count;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_Count <= '0;
      end else if (i_Load) begin
         r_Count <= i_LoadVal;
      end else if (i_Dec && (r_Count != '0)) begin
         r_Count <= r_Count - WAIT_W'(1);
      end
   end

   assign o_Zero = (r_Count == '0);

endmodule

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
// Memory-side responder on the multiplexed SysBus. Latches the address on
// ALE, decodes the BASE window and services reads (nOE) and writes (nWE)
// against a synchronous single-port SRAM with WAIT_STATES extra read cycles.
//   Clock, nReset : clock, asynchronous active-low reset
//   ALE, nME      : address latch enable, memory enable (high aborts)
//   nOE, nWE      : read / write strobes (active-low)
//   BusIn         : pad value (address or write data)
//   BusOut, BusOe : read data and pad drive enable
//   Rdy           : read data valid / write commit cycle
//   ProtErr       : nOE and nWE both low while selected in ADDR_HELD
//   SramAddr/Re/We/WData/RData : SRAM macro interface
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int unsigned                ADDR_W      = 10,
   parameter logic [BUS_W-ADDR_W-1:0]    BASE        = '0,
   parameter int unsigned                WAIT_STATES = 0
)
(
   input  logic              Clock,
   input  logic              nReset,
   input  logic              ALE,
   input  logic              nME,
   input  logic              nOE,
   input  logic              nWE,
   input  logic [BUS_W-1:0]  BusIn,
   output logic [BUS_W-1:0]  BusOut,
   output logic              BusOe,
   output logic              Rdy,
   output logic              ProtErr,
   output logic [ADDR_W-1:0] SramAddr,
   output logic              SramRe,
   output logic              SramWe,
   output logic [BUS_W-1:0]  SramWData,
   input  logic [BUS_W-1:0]  SramRData
);

   if (WAIT_STATES > 15) begin : g_bad_wait_states
      $error("mem_bus_responder: WAIT_STATES must be in 0..15");
   end
   if ((ADDR_W < 1) || (ADDR_W > BUS_W - 1)) begin : g_bad_addr_w
      $error("mem_bus_responder: ADDR_W must be in 1..15");
   end

   resp_state_t       r_State;
   resp_state_t       w_NextState;
   logic [ADDR_W-1:0] r_AddrReg;     // only the SRAM index bits are kept
   logic [BUS_W-1:0]  r_DataReg;
   logic              r_Sel;

   logic w_BusSel;
   logic w_LatchAddr;
   logic w_LatchWData;
   logic w_LatchRData;
   logic w_CntLoad;
   logic w_CntDec;
   logic w_CntZero;
   logic w_ProtErr;
   logic w_Drive;

   assign w_BusSel = (BusIn[BUS_W-1:ADDR_W] == BASE);

   mem_wait_counter u_wait_counter (
      .Clock     (Clock),
      .nReset    (nReset),
      .i_Load    (w_CntLoad),
      .i_LoadVal (WAIT_W'(WAIT_STATES)),
      .i_Dec     (w_CntDec),
      .o_Zero    (w_CntZero)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_State   <= S_IDLE;
         r_AddrReg <= '0;
         r_DataReg <= '0;
         r_Sel     <= 1'b0;
      end else begin
         r_State <= w_NextState;
         if (w_LatchAddr) begin
            r_AddrReg <= BusIn[ADDR_W-1:0];
            r_Sel     <= w_BusSel;
         end
         if (w_LatchWData) begin
            r_DataReg <= BusIn;
         end else if (w_LatchRData) begin
            r_DataReg <= SramRData;
         end
      end
   end

   always_comb begin
      w_NextState  = r_State;
      w_LatchAddr  = 1'b0;
      w_LatchWData = 1'b0;
      w_LatchRData = 1'b0;
      w_CntLoad    = 1'b0;
      w_CntDec     = 1'b0;
      w_ProtErr    = 1'b0;

      // nME high ends any transaction ahead of every other transition
      if ((r_State != S_IDLE) && nME) begin
         w_NextState = S_IDLE;
      end else begin
         unique case (r_State)
            S_IDLE: begin
               if (ALE && !nME) begin
                  w_LatchAddr = 1'b1;
                  w_NextState = S_ADDR_HELD;
               end
            end
            S_ADDR_HELD: begin
               // nME is known low here
               if (ALE) begin
                  w_LatchAddr = 1'b1;
               end else if (!r_Sel) begin
                  // unselected: strobes are ignored
               end else if (!nOE && !nWE) begin
                  w_ProtErr = 1'b1;
               end else if (!nOE) begin
                  w_NextState = S_RD_ISSUE;
               end else if (!nWE) begin
                  w_LatchWData = 1'b1;
                  w_NextState  = S_WR_COMMIT;
               end
            end
            S_RD_ISSUE: begin
               w_CntLoad   = 1'b1;
               w_NextState = S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (w_CntZero) begin
                  w_LatchRData = 1'b1;
                  w_NextState  = S_RD_DRIVE;
               end else begin
                  w_CntDec = 1'b1;
               end
            end
            S_RD_DRIVE: begin
               if (nOE) begin
                  w_NextState = S_ADDR_HELD;
               end
            end
            S_WR_COMMIT: begin
               w_NextState = S_WR_HOLD;
            end
            S_WR_HOLD: begin
               if (nWE) begin
                  w_NextState = S_ADDR_HELD;
               end
            end
            default: begin
               w_NextState = S_IDLE;
            end
         endcase
      end
   end

   // Drive follows the live strobes so the pads release in the same cycle
   // nOE or nME rises.
   assign w_Drive   = (r_State == S_RD_DRIVE) && !nOE && !nME;

   assign BusOe     = w_Drive;
   assign BusOut    = (r_State == S_RD_DRIVE) ? r_DataReg : '0;
   assign Rdy       = w_Drive || (r_State == S_WR_COMMIT);
   assign ProtErr   = w_ProtErr;
   assign SramAddr  = r_AddrReg;
   assign SramRe    = (r_State == S_RD_ISSUE);
   assign SramWe    = (r_State == S_WR_COMMIT);
   assign SramWData = r_DataReg;

endmodule

// File: tb/tb_mem_bus_responder.sv
`timescale 1ns/1ps
module tb_mem_bus_responder;

   typedef struct {
      int          inst;
      logic [15:0] a;
      logic [15:0] d;
      int          cyc;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } obs_t;

   logic        Clock  = 1'b0;
   logic        nReset = 1'b0;
   logic        ALE    = 1'b0;
   logic        nOE    = 1'b1;
   logic        nWE    = 1'b1;
   logic [15:0] BusIn  = 16'h0000;
   logic        nME       [2];
   logic [15:0] BusOut    [2];
   logic        BusOe     [2];
   logic        Rdy       [2];
   logic        ProtErr   [2];
   logic [9:0]  SramAddr  [2];
   logic        SramRe    [2];
   logic        SramWe    [2];
   logic [15:0] SramWData [2];
   logic [15:0] SramRData [2];
   logic [15:0] mem [2][1024];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   done = 1'b0;
   bit   prev_oe [2] = '{1'b0, 1'b0};
   exp_t q_re[$], q_rd[$], q_wr[$], q_pe[$];
   obs_t q_obs[$];

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // SRAM models: write on SramWe, read data valid the cycle after SramRe
   always @(posedge Clock) begin
      for (int i = 0; i < 2; i++) begin
         if (!nReset) begin
            mem[i][10'h012] <= (i == 0) ? 16'hBEEF : 16'hCAFE;
            mem[i][10'h3FF] <= 16'h5A0F;
            mem[i][10'h033] <= 16'h1234;
         end else begin
            if (SramWe[i]) mem[i][SramAddr[i]] <= SramWData[i];
            if (SramRe[i]) SramRData[i] <= mem[i][SramAddr[i]];
         end
      end
   end

   mem_bus_responder #(.ADDR_W(10), .BASE(6'd0), .WAIT_STATES(0)) u_ws0 (
      .Clock(Clock), .nReset(nReset), .ALE(ALE), .nME(nME[0]), .nOE(nOE), .nWE(nWE),
      .BusIn(BusIn), .BusOut(BusOut[0]), .BusOe(BusOe[0]), .Rdy(Rdy[0]),
      .ProtErr(ProtErr[0]), .SramAddr(SramAddr[0]), .SramRe(SramRe[0]),
      .SramWe(SramWe[0]), .SramWData(SramWData[0]), .SramRData(SramRData[0])
   );

   mem_bus_responder #(.ADDR_W(10), .BASE(6'd0), .WAIT_STATES(3)) u_ws3 (
      .Clock(Clock), .nReset(nReset), .ALE(ALE), .nME(nME[1]), .nOE(nOE), .nWE(nWE),
      .BusIn(BusIn), .BusOut(BusOut[1]), .BusOe(BusOe[1]), .Rdy(Rdy[1]),
      .ProtErr(ProtErr[1]), .SramAddr(SramAddr[1]), .SramRe(SramRe[1]),
      .SramWe(SramWe[1]), .SramWData(SramWData[1]), .SramRData(SramRData[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard: sole owner of the counters
   always @(negedge Clock) begin
      exp_t e;
      obs_t o;
      while (q_obs.size() > 0) begin
         o = q_obs.pop_front();
         check(o.name, o.act, o.exp);
      end
      if (nReset) begin
         for (int i = 0; i < 2; i++) begin
            if (SramRe[i]) begin
               if (q_re.size() == 0 || q_re[0].inst != i) check("unexpected_sram_re", 32'(SramRe[i]), 0);
               else begin
                  e = q_re.pop_front();
                  check("sram_re_addr", 32'(SramAddr[i]), 32'(e.a[9:0]));
               end
            end
            if (BusOe[i] && !prev_oe[i]) begin
               if (q_rd.size() == 0 || q_rd[0].inst != i) check("unexpected_bus_oe", 32'(BusOe[i]), 0);
               else begin
                  e = q_rd.pop_front();
                  check("rd_data", 32'(BusOut[i]), 32'(e.d));
                  check("rd_latency", 32'(cyc), 32'(e.cyc));
                  check("rd_addr", 32'(SramAddr[i]), 32'(e.a[9:0]));
               end
            end
            if (SramWe[i]) begin
               if (q_wr.size() == 0 || q_wr[0].inst != i) check("unexpected_sram_we", 32'(SramWe[i]), 0);
               else begin
                  e = q_wr.pop_front();
                  check("wr_addr", 32'(SramAddr[i]), 32'(e.a[9:0]));
                  check("wr_data", 32'(SramWData[i]), 32'(e.d));
                  check("wr_rdy", 32'(Rdy[i]), 1);
               end
            end
            if (ProtErr[i]) begin
               if (q_pe.size() == 0 || q_pe[0].inst != i) check("unexpected_proterr", 32'(ProtErr[i]), 0);
               else begin
                  e = q_pe.pop_front();
                  check("proterr_addr", 32'(SramAddr[i]), 32'(e.a[9:0]));
               end
            end
            if (Rdy[i] !== (BusOe[i] | SramWe[i]))
               check("rdy_consistency", 32'(Rdy[i]), 32'(BusOe[i] | SramWe[i]));
            prev_oe[i] = BusOe[i];
         end
      end
      if (done) begin
         check("re_queue_drained", 32'(q_re.size()), 0);
         check("rd_queue_drained", 32'(q_rd.size()), 0);
         check("wr_queue_drained", 32'(q_wr.size()), 0);
         check("pe_queue_drained", 32'(q_pe.size()), 0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
      if (cyc > 5000) begin
         $display("FAIL watchdog: got cycle %0d, expected end before 5000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic note(input string n, input logic [31:0] a, input logic [31:0] e);
      q_obs.push_back('{n, a, e});
   endtask

   task automatic addr_phase(input int i, input logic [15:0] a);
      nME[i] = 1'b0;
      nME[1-i] = 1'b1;
      ALE = 1'b1;
      BusIn = a;
      tick();
      ALE = 1'b0;
      BusIn = 16'h0000;
   endtask

   task automatic wait_oe(input int i, input int lim);
      bit ok = 1'b0;
      for (int k = 0; k < lim; k++) begin
         if (BusOe[i]) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      note("bus_oe_timeout", 32'(ok), 1);
   endtask

   // BusOe is expected after the edge numbered 3+ws, counting the edge that
   // samples nOE low as the first.
   task automatic read_start(input int i, input logic [15:0] a, input logic [15:0] d, input int ws);
      q_re.push_back('{i, a, 16'h0000, 0});
      q_rd.push_back('{i, a, d, cyc + 3 + ws});
      nOE = 1'b0;
      tick();
      wait_oe(i, ws + 8);
   endtask

   task automatic do_read(input int i, input logic [15:0] a, input logic [15:0] d, input int ws);
      read_start(i, a, d, ws);
      tick();
      nOE = 1'b1;
      #1;
      note("oe_release", 32'(BusOe[i]), 0);
      note("rdy_release", 32'(Rdy[i]), 0);
      tick();
   endtask

   initial begin
      bit any;
      nME[0] = 1'b1;
      nME[1] = 1'b1;
      #2;
      for (int i = 0; i < 2; i++) begin
         note("rst_busout", 32'(BusOut[i]), 0);
         note("rst_busoe", 32'(BusOe[i]), 0);
         note("rst_rdy", 32'(Rdy[i]), 0);
         note("rst_proterr", 32'(ProtErr[i]), 0);
         note("rst_sramaddr", 32'(SramAddr[i]), 0);
         note("rst_sramre", 32'(SramRe[i]), 0);
         note("rst_sramwe", 32'(SramWe[i]), 0);
         note("rst_sramwdata", 32'(SramWData[i]), 0);
      end
      repeat (2) @(posedge Clock);
      #1;
      nReset = 1'b1;
      tick();

      // reads, no wait states, including top of the window
      addr_phase(0, 16'h0012);
      do_read(0, 16'h0012, 16'hBEEF, 0);
      addr_phase(0, 16'h03FF);
      do_read(0, 16'h03FF, 16'h5A0F, 0);

      // write with a long nWE pulse, data changes after the sampling edge
      addr_phase(0, 16'h0005);
      q_wr.push_back('{0, 16'h0005, 16'hA5A5, 0});
      nWE = 1'b0;
      BusIn = 16'hA5A5;
      tick();
      BusIn = 16'h1111;
      repeat (3) tick();
      nWE = 1'b1;
      BusIn = 16'h0000;
      tick();
      do_read(0, 16'h0005, 16'hA5A5, 0);

      // unselected address just past the window
      addr_phase(0, 16'h0400);
      nOE = 1'b0;
      any = 1'b0;
      repeat (8) begin
         tick();
         any |= BusOe[0] | SramRe[0] | Rdy[0];
      end
      nOE = 1'b1;
      tick();
      note("unsel_quiet", 32'(any), 0);

      // both strobes low together
      addr_phase(0, 16'h0012);
      q_pe.push_back('{0, 16'h0012, 16'h0000, 0});
      nOE = 1'b0;
      nWE = 1'b0;
      tick();
      nOE = 1'b1;
      nWE = 1'b1;
      repeat (2) tick();

      // asynchronous reset while driving read data
      addr_phase(0, 16'h0012);
      read_start(0, 16'h0012, 16'hBEEF, 0);
      @(negedge Clock);
      #1;
      nReset = 1'b0;
      #1;
      note("rst_mid_busoe", 32'(BusOe[0]), 0);
      note("rst_mid_rdy", 32'(Rdy[0]), 0);
      note("rst_mid_sramre", 32'(SramRe[0]), 0);
      note("rst_mid_sramwe", 32'(SramWe[0]), 0);
      note("rst_mid_busout", 32'(BusOut[0]), 0);
      nReset = 1'b1;
      any = 1'b0;
      repeat (4) begin
         tick();
         any |= BusOe[0] | SramRe[0] | Rdy[0];
      end
      note("post_reset_idle", 32'(any), 0);
      nOE = 1'b1;
      tick();

      // three wait states
      addr_phase(1, 16'h0033);
      do_read(1, 16'h0033, 16'h1234, 3);

      // nME rises while waiting on the SRAM
      addr_phase(1, 16'h0012);
      q_re.push_back('{1, 16'h0012, 16'h0000, 0});
      nOE = 1'b0;
      repeat (3) tick();
      nME[1] = 1'b1;
      tick();
      nME[1] = 1'b0;
      any = 1'b0;
      repeat (8) begin
         tick();
         any |= BusOe[1] | Rdy[1];
      end
      nOE = 1'b1;
      tick();
      note("abort_no_oe", 32'(any), 0);

      nME[0] = 1'b1;
      nME[1] = 1'b1;
      repeat (2) tick();
      done = 1'b1;
   end

endmodule
